// File: rtl/fetch_sequencer.sv
// fetch_sequencer: CPU front end. Owns the PC, fetches each instruction word
// from ROM into the instruction register, then walks it through the
// decode / execute / write-back / jump phases as one-hot strobes that act as
// clock enables for the control unit, ALU and register file.
module fetch_sequencer #(
  parameter int PC_W    = 15,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               rom_valid,
  input  logic               set_pc,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               halt,
  output logic [PC_W-1:0]    rom_addr,
  output logic               rom_req,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_phase,
  output logic               decode_phase,
  output logic               exec_phase,
  output logic               wrbk_phase,
  output logic               jump_phase,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WRBK   = 3'd3,
    S_JUMP   = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  state_t state, state_nxt;

  // State register plus the architectural state it owns (pc, instr, counter).
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_FETCH;
      pc            <= '0;
      instr         <= '0;
      retired_count <= '0;
    end else begin
      state <= state_nxt;
      // instr only loads on the accepting FETCH edge, so it stays stable
      // from DECODE through the end of JUMP.
      if (state == S_FETCH && rom_valid)
        instr <= rom_data;
      // set_pc / jump_target only matter here; elsewhere they are ignored.
      if (state == S_JUMP) begin
        pc            <= set_pc ? jump_target : pc + PC_W'(1);
        retired_count <= retired_count + CNT_W'(1);
      end
    end
  end

  // Next-state logic and Moore strobe decode; strobes are squashed while rst
  // is high so downstream enables never fire during reset.
  always_comb begin
    state_nxt    = state;
    fetch_phase  = 1'b0;
    decode_phase = 1'b0;
    exec_phase   = 1'b0;
    wrbk_phase   = 1'b0;
    jump_phase   = 1'b0;
    halted       = 1'b0;
    case (state)
      S_FETCH: begin
        fetch_phase = !rst;
        if (rom_valid) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        decode_phase = !rst;
        state_nxt    = S_EXEC;
      end
      S_EXEC: begin
        exec_phase = !rst;
        state_nxt  = S_WRBK;
      end
      S_WRBK: begin
        wrbk_phase = !rst;
        state_nxt  = S_JUMP;
      end
      S_JUMP: begin
        jump_phase = !rst;
        // halt only takes effect at an instruction boundary.
        state_nxt  = halt ? S_HALTED : S_FETCH;
      end
      S_HALTED: begin
        halted = !rst;
        if (!halt) state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  assign rom_addr = pc;
  assign rom_req  = fetch_phase;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one task per scenario, inline checks.
module tb_fetch_sequencer;
  localparam int PC_W = 15, INSTR_W = 16, CNT_W = 16;
  localparam logic [5:0] F = 6'b000001, D = 6'b000010, E = 6'b000100,
                         W = 6'b001000, J = 6'b010000, H = 6'b100000;

  logic clk = 1'b0, rst = 1'b1, rom_valid = 1'b0, set_pc = 1'b0, halt = 1'b0;
  logic [INSTR_W-1:0] rom_data = '0;
  logic [PC_W-1:0]    jump_target = '0;

  logic [PC_W-1:0]    rom_addr, pc;
  logic [INSTR_W-1:0] instr;
  logic               rom_req, fetch_phase, decode_phase, exec_phase, wrbk_phase, jump_phase, halted;
  logic [CNT_W-1:0]   retired_count;

  // Narrow-counter twin in lockstep, so counter wrap is reachable quickly.
  logic [PC_W-1:0]    s_rom_addr, s_pc;
  logic [INSTR_W-1:0] s_instr;
  logic               s_rom_req, s_fp, s_dp, s_ep, s_wp, s_jp, s_halted;
  logic [3:0]         s_count;

  int checks = 0, failures = 0;

  wire [5:0] strb = {halted, jump_phase, wrbk_phase, exec_phase, decode_phase, fetch_phase};

  fetch_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rom_data(rom_data), .rom_valid(rom_valid), .set_pc(set_pc),
    .jump_target(jump_target), .halt(halt), .rom_addr(rom_addr), .rom_req(rom_req),
    .instr(instr), .pc(pc), .fetch_phase(fetch_phase), .decode_phase(decode_phase),
    .exec_phase(exec_phase), .wrbk_phase(wrbk_phase), .jump_phase(jump_phase),
    .halted(halted), .retired_count(retired_count));

  fetch_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .rom_data(rom_data), .rom_valid(rom_valid), .set_pc(set_pc),
    .jump_target(jump_target), .halt(halt), .rom_addr(s_rom_addr), .rom_req(s_rom_req),
    .instr(s_instr), .pc(s_pc), .fetch_phase(s_fp), .decode_phase(s_dp),
    .exec_phase(s_ep), .wrbk_phase(s_wp), .jump_phase(s_jp),
    .halted(s_halted), .retired_count(s_count));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Stimulus only: one full instruction from FETCH, ROM answers immediately.
  task automatic run_instr(input logic sp, input logic [PC_W-1:0] tgt);
    rom_data = 16'h7000; rom_valid = 1'b1; step;
    rom_valid = 1'b0; step; step; step;
    set_pc = sp; jump_target = tgt; step;
    set_pc = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; step; step;
    checks++; if (strb !== 6'b0 || rom_req !== 1'b0) begin failures++; $display("FAIL reset_strobes strb=%b req=%b exp=000000/0", strb, rom_req); end
    checks++; if (pc !== 15'd0 || rom_addr !== 15'd0) begin failures++; $display("FAIL reset_pc pc=%h addr=%h exp=0", pc, rom_addr); end
    checks++; if (instr !== 16'd0 || retired_count !== 16'd0) begin failures++; $display("FAIL reset_regs instr=%h cnt=%0d exp=0/0", instr, retired_count); end
    rst = 1'b0; #1;
    checks++; if (strb !== F || rom_req !== 1'b1) begin failures++; $display("FAIL reset_release strb=%b req=%b exp=%b/1", strb, rom_req, F); end
  endtask

  task automatic test_straight;
    for (int i = 0; i < 3; i++) begin
      checks++; if (strb !== F || rom_addr !== 15'(i)) begin failures++; $display("FAIL straight_fetch%0d strb=%b addr=%h exp=%b/%h", i, strb, rom_addr, F, i); end
      rom_data = 16'hC000 + 16'(i); rom_valid = 1'b1; step; rom_valid = 1'b0;
      checks++; if (strb !== D || instr !== 16'hC000 + 16'(i)) begin failures++; $display("FAIL straight_decode%0d strb=%b instr=%h", i, strb, instr); end
      step;
      checks++; if (strb !== E) begin failures++; $display("FAIL straight_exec%0d strb=%b exp=%b", i, strb, E); end
      step;
      checks++; if (strb !== W) begin failures++; $display("FAIL straight_wrbk%0d strb=%b exp=%b", i, strb, W); end
      step;
      checks++; if (strb !== J || pc !== 15'(i)) begin failures++; $display("FAIL straight_jump%0d strb=%b pc=%h", i, strb, pc); end
      step;
      checks++; if (retired_count !== 16'(i + 1)) begin failures++; $display("FAIL straight_count%0d cnt=%0d exp=%0d", i, retired_count, i + 1); end
    end
    checks++; if (strb !== F || rom_addr !== 15'd3) begin failures++; $display("FAIL straight_end strb=%b addr=%h exp=%b/3", strb, rom_addr, F); end
  endtask

  task automatic test_rom_wait;
    for (int c = 0; c < 5; c++) begin
      checks++; if (strb !== F || pc !== 15'd3 || rom_req !== 1'b1) begin failures++; $display("FAIL wait_cycle%0d strb=%b pc=%h req=%b", c, strb, pc, rom_req); end
      if (c < 4) step;
    end
    rom_data = 16'h5A5A; rom_valid = 1'b1; step;
    checks++; if (strb !== D || instr !== 16'h5A5A) begin failures++; $display("FAIL wait_decode strb=%b instr=%h exp=%b/5a5a", strb, instr, D); end
    // Stray rom_valid and set_pc outside their phases must be ignored.
    rom_data = 16'hDEAD; set_pc = 1'b1; jump_target = 15'h0055; step;
    checks++; if (strb !== E || instr !== 16'h5A5A) begin failures++; $display("FAIL wait_stray_valid strb=%b instr=%h exp=%b/5a5a", strb, instr, E); end
    rom_valid = 1'b0; step; set_pc = 1'b0; step;
    checks++; if (strb !== J || instr !== 16'h5A5A) begin failures++; $display("FAIL wait_jump strb=%b instr=%h", strb, instr); end
    step;
    checks++; if (pc !== 15'd4 || strb !== F) begin failures++; $display("FAIL stray_set_pc pc=%h strb=%b exp=4/%b", pc, strb, F); end
  endtask

  task automatic test_jump;
    run_instr(1'b1, 15'h0123);
    checks++; if (rom_addr !== 15'h0123 || retired_count !== 16'd5) begin failures++; $display("FAIL jump_taken addr=%h cnt=%0d exp=0123/5", rom_addr, retired_count); end
    run_instr(1'b1, 15'h7FFF);
    checks++; if (pc !== 15'h7FFF) begin failures++; $display("FAIL jump_top pc=%h exp=7fff", pc); end
    run_instr(1'b0, 15'h1234);
    checks++; if (pc !== 15'h0000 || retired_count !== 16'd7) begin failures++; $display("FAIL pc_wrap pc=%h cnt=%0d exp=0000/7", pc, retired_count); end
  endtask

  task automatic test_halt;
    rom_data = 16'h1111; rom_valid = 1'b1; step;
    rom_valid = 1'b0; step;
    checks++; if (strb !== E) begin failures++; $display("FAIL halt_exec strb=%b exp=%b", strb, E); end
    halt = 1'b1; set_pc = 1'b1; jump_target = 15'h0040; step;
    checks++; if (strb !== W) begin failures++; $display("FAIL halt_no_stall strb=%b exp=%b", strb, W); end
    step;
    checks++; if (strb !== J) begin failures++; $display("FAIL halt_jump strb=%b exp=%b", strb, J); end
    step;
    jump_target = 15'h0099; rom_data = 16'hBEEF; rom_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (strb !== H || rom_req !== 1'b0) begin failures++; $display("FAIL halted%0d strb=%b req=%b exp=%b/0", c, strb, rom_req, H); end
      checks++; if (pc !== 15'h0040 || instr !== 16'h1111 || retired_count !== 16'd8) begin failures++; $display("FAIL halt_frozen%0d pc=%h instr=%h cnt=%0d", c, pc, instr, retired_count); end
      step;
    end
    halt = 1'b0; set_pc = 1'b0; rom_valid = 1'b0; step;
    checks++; if (strb !== F || rom_addr !== 15'h0040) begin failures++; $display("FAIL halt_resume strb=%b addr=%h exp=%b/0040", strb, rom_addr, F); end
  endtask

  task automatic test_reset_mid;
    run_instr(1'b1, 15'h0010);
    rom_data = 16'h2222; rom_valid = 1'b1; step;
    rom_valid = 1'b0; step; step;
    checks++; if (strb !== W || pc !== 15'h0010 || retired_count !== 16'd9) begin failures++; $display("FAIL mid_setup strb=%b pc=%h cnt=%0d", strb, pc, retired_count); end
    rst = 1'b1; set_pc = 1'b1; step;
    checks++; if (strb !== 6'b0 || pc !== 15'd0 || instr !== 16'd0 || retired_count !== 16'd0) begin failures++; $display("FAIL mid_reset strb=%b pc=%h instr=%h cnt=%0d", strb, pc, instr, retired_count); end
    rst = 1'b0; set_pc = 1'b0; #1;
    checks++; if (strb !== F || rom_addr !== 15'd0) begin failures++; $display("FAIL mid_release strb=%b addr=%h exp=%b/0", strb, rom_addr, F); end
  endtask

  task automatic test_count_wrap;
    for (int i = 0; i < 15; i++) run_instr(1'b0, 15'h0);
    checks++; if (retired_count !== 16'd15 || s_count !== 4'd15) begin failures++; $display("FAIL cnt_pre_wrap cnt=%0d small=%0d exp=15/15", retired_count, s_count); end
    run_instr(1'b0, 15'h0);
    checks++; if (retired_count !== 16'd16 || s_count !== 4'd0 || pc !== 15'd16) begin failures++; $display("FAIL cnt_wrap cnt=%0d small=%0d pc=%h exp=16/0/0010", retired_count, s_count, pc); end
  endtask

  initial begin
    test_reset;
    test_straight;
    test_rom_wait;
    test_jump;
    test_halt;
    test_reset_mid;
    test_count_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
